// File: rtl/tube_display_ctrl.sv
// Binary-to-BCD sequencer for the digital_tube driver: accepts a value, runs a
// double-dabble conversion, then loads digits, blank mask and overflow atomically.
module tube_display_ctrl #(
    parameter int VAL_W      = 14,
    parameter bit BLANK_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VAL_W-1:0] in_value,
    output logic             en,
    output logic [3:0]       single_digit,
    output logic [3:0]       ten_digit,
    output logic [3:0]       hundred_digit,
    output logic [3:0]       kilo_digit,
    output logic [3:0]       blank,
    output logic             ovf,
    output logic             busy
);

    // state | meaning
    // IDLE  | waiting for a value, in_ready high
    // SHIFT | one double-dabble step per cycle, VAL_W steps
    // LOAD  | copy accumulator to the display outputs
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    localparam int              CNT_W   = 5;
    localparam logic [VAL_W-1:0] SAT_VAL = VAL_W'(9999);

    state_t             state_q, state_d;
    logic [VAL_W-1:0]   bin_q, bin_d;
    logic [15:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [15:0]        digits_q, digits_d;
    logic [3:0]         blank_q, blank_d;
    logic               ovf_q, ovf_d;
    logic               en_q, en_d;
    logic [3:0]         blank_calc;

    function automatic logic [3:0] adj_nib(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        blank_calc = 4'b0000;
        if (BLANK_ZERO) begin
            blank_calc[3] = (bcd_q[15:12] == 4'd0);
            blank_calc[2] = blank_calc[3] && (bcd_q[11:8] == 4'd0);
            blank_calc[1] = blank_calc[2] && (bcd_q[7:4] == 4'd0);
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        en_d       = en_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_value > SAT_VAL) begin
                        bin_d      = SAT_VAL;
                        ovf_pend_d = 1'b1;
                    end else begin
                        bin_d      = in_value;
                        ovf_pend_d = 1'b0;
                    end
                    bcd_d   = 16'd0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Saturated input never exceeds 9999, so nothing shifts out of the top nibble.
                bcd_d = 16'({adj_nib(bcd_q[15:12]), adj_nib(bcd_q[11:8]),
                             adj_nib(bcd_q[7:4]), adj_nib(bcd_q[3:0]), bin_q[VAL_W-1]});
                bin_d = {bin_q[VAL_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                digits_d = bcd_q;
                blank_d  = blank_calc;
                ovf_d    = ovf_pend_q;
                en_d     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= 16'd0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= 16'd0;
            blank_q    <= 4'b1110;
            ovf_q      <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            en_q       <= en_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign busy          = !in_ready;
    assign en            = en_q;
    assign kilo_digit    = digits_q[15:12];
    assign hundred_digit = digits_q[11:8];
    assign ten_digit     = digits_q[7:4];
    assign single_digit  = digits_q[3:0];
    assign blank         = blank_q;
    assign ovf           = ovf_q;

endmodule

// File: doc/tube_display_ctrl.md
# tube_display_ctrl

Sequencing controller for the 4-digit seven-segment driver `digital_tube`. It accepts a binary value over a valid/ready handshake and converts it to four BCD digits with a sequential shift-and-add-3 (double-dabble) engine. It then loads the digits atomically into the driver's digit inputs and drives the driver's `en`. It also produces a leading-zero blank mask and an overflow flag, so upstream logic never handles BCD or display timing.

## Interface

Parameters:
- `VAL_W`, default 14: width of `in_value`; legal range 14..20. The conversion shift count equals `VAL_W`.
- `BLANK_ZERO`, default 1: 1 enables leading-zero blanking; 0 forces `blank` = 4'b0000.

Ports:
- `clk`  in  1  the single clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  `in_value` is valid.
- `in_ready`  out  1  controller can accept a value (high only in IDLE).
- `in_value`  in  VAL_W  unsigned binary value to display.
- `en`  out  1  to driver `en`; low until the first load completes.
- `single_digit`  out  4  BCD units.
- `ten_digit`  out  4  BCD tens.
- `hundred_digit`  out  4  BCD hundreds.
- `kilo_digit`  out  4  BCD thousands.
- `blank`  out  4  per-digit blank mask; bit3 = kilo … bit0 = single; 1 = blank.
- `ovf`  out  1  the displayed value was saturated.
- `busy`  out  1  conversion in progress (state is not IDLE).

## Operation

- FSM states: IDLE, SHIFT, LOAD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` && `in_ready`, capture `in_value` into the shift register.
  - If `in_value` > 9999, capture 9999 instead and set an internal ovf_pending; otherwise clear ovf_pending.
  - Clear the 16-bit BCD accumulator, set the counter to 0, go to SHIFT.
- SHIFT, one step per cycle:
  - Each BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The counter increments; after `VAL_W` steps, go to LOAD.
- LOAD:
  - Register the accumulator nibbles into the four digit outputs.
  - Register `blank` and ovf_pending into `ovf`; set `en`=1.
  - Return to IDLE.
- Digit outputs, `blank` and `ovf` change only in LOAD, so the display never shows partial results. Old values are held throughout SHIFT.
- `in_value` and `in_valid` are ignored outside IDLE; no queueing.
- Blanking with BLANK_ZERO=1:
  - blank[3] = (kilo==0).
  - blank[2] = blank[3] && (hundred==0).
  - blank[1] = blank[2] && (ten==0).
  - blank[0] = 0 always, so value 0 shows a single "0".
- Digits are always valid BCD 0..9; the driver is never sent 10..15.
- `en` stays 1 after the first load until reset.

## Timing

- Reset (`rstn`=0 at a clk edge):
  - state=IDLE, all digits 0, `blank`=4'b1110, `ovf`=0, `en`=0.
  - `in_ready`=1, `busy`=0.
  - Any conversion in flight is aborted with no load.
- Accept at edge E0 (`in_valid`&&`in_ready` high before E0):
  - Shift steps occur at edges E1..E`VAL_W`.
  - LOAD registers the outputs at edge E`VAL_W`+1 (E15 for the default).
  - Outputs are visible in the cycle after E15.
- `in_ready` is low from after E0 through E15 and high again after E15. The next accept is at E16 at the earliest, giving a throughput of one value per `VAL_W`+2 cycles.
- `busy` = !`in_ready`.
- `in_valid` held continuously: values are accepted every 16 cycles; each accept samples the value present at that edge.
- Simultaneous `rstn`=0 and `in_valid`=1: reset wins; nothing is accepted.
- Saturation boundary: 9999 gives `ovf`=0; 10000 gives 9999 with `ovf`=1.
- Max VAL_W=20 value 1048575 gives 9999 with `ovf`=1.

## Test plan

- Reset: hold `rstn`=0 for 2 cycles, release → digits 0/0/0/0, `blank`=1110, `en`=0, `ovf`=0, `in_ready`=1, `busy`=0.
- Convert 452 → exactly 15 edges after accept, kilo/hundred/ten/single = 0/4/5/2, `blank`=1000, `en`=1, `ovf`=0. Outputs unchanged during edges E1..E14.
- Convert 0 then 9999 → first load 0/0/0/0 with `blank`=1110; second load 9/9/9/9 with `blank`=0000, `ovf`=0.
- Convert 12345 → 9/9/9/9 with `ovf`=1. Then convert 10 → 0/0/1/0, `blank`=1100, `ovf`=0.
- Hold `in_valid`=1 with 7, changing `in_value` to 1000 at E3 → first load shows 0/0/0/7. Second accept is at E16, sampling 1000; it loads 1/0/0/0 at E31. `in_ready`=0 throughout E1..E15.
- Accept 3456 after a prior load of 0/4/5/2, then assert `rstn`=0 at E7 → reset values appear (`en`=0, digits 0). No 3/4/5/6 load ever occurs, and `in_ready`=1 after release.
